add_mul_seq: RTL and testbench



---
 rtl/add_mul_seq.sv | 108 ++++++++++
 tb/tb_add_mul_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/add_mul_seq.sv
// add_mul_seq: sequential 32x32 -> 32 shift-and-add multiplier.
// Uses an external shared 32-bit adder (add_a + add_b -> add_c) for the
// accumulation step, one partial product per RUN cycle.
module add_mul_seq #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_c,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] product_q, product_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        last_step;

    // Final step: all 32 bits consumed, or (optionally) no set multiplier bits left.
    assign last_step = (cnt_q == 5'd31) ||
                       (EARLY_EXIT && ((mplier_q >> 1) == 32'd0));

    // Next-state and datapath update for the three-state sequencer.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = 32'd0;
                    cnt_d    = 5'd0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = add_c;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (last_step) begin
                    product_d = add_c;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status flags are registered copies of the next state, so they
        // carry no combinational path from start.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // All state, with asynchronous clear on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= 32'd0;
            mplier_q  <= 32'd0;
            acc_q     <= 32'd0;
            cnt_q     <= 5'd0;
            product_q <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Adder operands are forced to zero outside RUN so the shared adder stays quiet.
    assign add_a = (state_q == RUN) ? acc_q : 32'd0;
    assign add_b = ((state_q == RUN) && mplier_q[0]) ? mcand_q : 32'd0;

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_add_mul_seq.sv
// Bench for add_mul_seq: one instance with early exit, one without, sharing
// stimulus. Each instance gets its own model of the external 32-bit adder.
module tb_add_mul_seq;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] op_a, op_b;

    logic [31:0] a1_a, a1_b, a1_c, prod1;
    logic        busy1, done1;
    logic [31:0] a0_a, a0_b, a0_c, prod0;
    logic        busy0, done0;

    assign a1_c = a1_a + a1_b;
    assign a0_c = a0_a + a0_b;

    add_mul_seq #(.EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .add_a(a1_a), .add_b(a1_b), .add_c(a1_c),
        .busy(busy1), .done(done1), .product(prod1));

    add_mul_seq #(.EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .add_a(a0_a), .add_b(a0_b), .add_c(a0_c),
        .busy(busy0), .done(done0), .product(prod0));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prod;
        int          cyc_ee;   // RUN cycles with early exit
    } vec_t;

    // One operation on both instances; op_a/op_b are scrambled right after
    // acceptance to show the latched operands are used.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int c1, output int c0, output int d1, output int d0,
                          output logic [31:0] p1, output logic [31:0] p0,
                          output logic ov, output logic bnz);
        c1 = 0; c0 = 0; d1 = 0; d0 = 0; p1 = '0; p0 = '0; ov = 1'b0; bnz = 1'b0;
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op_a = ~a; op_b = ~b;
        for (int i = 0; i < 40; i++) begin
            if (busy1) c1++;
            if (busy0) c0++;
            if (done1) begin d1++; p1 = prod1; end
            if (done0) begin d0++; p0 = prod0; end
            if ((busy1 && done1) || (busy0 && done0)) ov = 1'b1;
            if (b == 32'd0 && a1_b != 32'd0) bnz = 1'b1;
            if (d0 > 0 && d1 > 0) break;
            @(negedge clk);
        end
    endtask

    vec_t vecs[10];

    initial begin
        int c1, c0, d1, d0, last_done, ndone, n_ovl;
        logic [31:0] p1, p0;
        logic ov, bnz;

        vecs[0] = '{32'd100,        32'd100,        32'd10000,      7};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 32};
        vecs[2] = '{32'h1234_5678,  32'd0,          32'd0,          1};
        vecs[3] = '{32'd3,          32'd5,          32'd15,         3};
        vecs[4] = '{32'd7,          32'd9,          32'd63,         4};
        vecs[5] = '{32'd6,          32'd7,          32'd42,         3};
        vecs[6] = '{32'h0001_0000,  32'h0001_0000,  32'd0,         17};
        vecs[7] = '{32'hDEAD_BEEF,  32'd1,          32'hDEAD_BEEF,  1};
        vecs[8] = '{32'd1,          32'h8000_0000,  32'h8000_0000, 32};
        vecs[9] = '{32'h1234_5678,  32'h10,         32'h2345_6780,  5};

        // Reset state
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy",    {30'd0, busy1, busy0}, 32'd0);
        chk("rst_done",    {30'd0, done1, done0}, 32'd0);
        chk("rst_product", prod1 | prod0, 32'd0);
        chk("rst_adder",   a1_a | a1_b | a0_a | a0_b, 32'd0);
        rst = 1'b0;

        // Table of single operations
        foreach (vecs[k]) begin
            run_op(vecs[k].a, vecs[k].b, c1, c0, d1, d0, p1, p0, ov, bnz);
            chk($sformatf("v%0d_prod_ee1", k), p1, vecs[k].prod);
            chk($sformatf("v%0d_prod_ee0", k), p0, vecs[k].prod);
            chk($sformatf("v%0d_cyc_ee1", k), c1, vecs[k].cyc_ee);
            chk($sformatf("v%0d_cyc_ee0", k), c0, 32);
            chk($sformatf("v%0d_ndone", k), {d1[15:0], d0[15:0]}, {16'd1, 16'd1});
            chk($sformatf("v%0d_overlap", k), {31'd0, ov}, 32'd0);
            if (vecs[k].b == 32'd0) chk($sformatf("v%0d_addb_zero", k), {31'd0, bnz}, 32'd0);
        end

        // Idle adder operands between operations
        @(negedge clk);
        chk("idle_adder", a1_a | a1_b | a0_a | a0_b, 32'd0);

        // start held high: 3*5 back to back, period = 3 RUN + DONE + IDLE
        @(negedge clk);
        op_a = 32'd3; op_b = 32'd5; start = 1'b1;
        last_done = -1; ndone = 0; n_ovl = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((busy1 && done1) || (busy0 && done0)) n_ovl++;
            if (done1) begin
                ndone++;
                chk("held_prod", prod1, 32'd15);
                if (last_done >= 0) chk("held_period", i - last_done, 5);
                last_done = i;
            end
        end
        start = 1'b0;
        chk("held_overlap", n_ovl, 0);
        chk("held_count", {31'd0, ndone >= 19}, 32'd1);

        // Abort with rst during the second RUN cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op_a = 32'd7; op_b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_running", {31'd0, busy1}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy",    {30'd0, busy1, busy0}, 32'd0);
        chk("abort_done",    {30'd0, done1, done0}, 32'd0);
        chk("abort_product", prod1 | prod0, 32'd0);
        chk("abort_adder",   a1_a | a1_b | a0_a | a0_b, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done1 || done0 || busy1 || busy0) ndone++;
        end
        chk("abort_quiet", ndone, 0);
        run_op(32'd7, 32'd9, c1, c0, d1, d0, p1, p0, ov, bnz);
        chk("after_abort_prod1", p1, 32'd63);
        chk("after_abort_prod0", p0, 32'd63);
        chk("after_abort_cyc1", c1, 4);

        // start re-pulsed with new operands mid-RUN
        @(negedge clk);
        op_a = 32'd6; op_b = 32'd7; start = 1'b1;
        d1 = 0; d0 = 0; p1 = '0; p0 = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin start = 1'b0; op_a = '0; op_b = '0; end
            if (i == 1) begin start = 1'b1; op_a = 32'd99; op_b = 32'd99; end
            if (i == 2) start = 1'b0;
            if (done1) begin d1++; p1 = prod1; end
            if (done0) begin d0++; p0 = prod0; end
        end
        chk("repulse_ndone1", d1, 1);
        chk("repulse_ndone0", d0, 1);
        chk("repulse_prod1", p1, 32'd42);
        chk("repulse_prod0", p0, 32'd42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
